hilo_mult_sequencer: RTL
========================

Name: hilo_mult_sequencer

Overview:
- Multi-cycle multiply/accumulate unit that owns the HI/LO register pair.
- Executes mult, multu, madd, msub, mthi and mtlo as a sequenced iterative shift-add engine, so the single-cycle ALU no longer holds a combinational 32x32 multiplier.
- Sits beside the EX stage. The pipeline issues commands with Start and reads Hi/Lo for mfhi/mflo.
- Stall holds the pipeline when an mfhi/mflo arrives while an operation is in flight.

Parameters:
- WIDTH, 32: operand width; Hi and Lo are each WIDTH bits.
- STEP, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4, and STEP must divide WIDTH. N = WIDTH/STEP.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  command valid; sampled only in IDLE.
- Op  in  3  command: 000 mult, 001 multu, 010 madd (signed), 011 msub (signed), 100 mthi, 101 mtlo, 11x reserved.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- Flush  in  1  abort in-flight operation (branch/exception squash).
- HiLoRead  in  1  decode stage holds mfhi/mflo.
- Hi  out  WIDTH  architectural HI.
- Lo  out  WIDTH  architectural LO.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result in this cycle.
- Stall  out  1  equals Busy & HiLoRead (combinational).

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, internal accumulator, counter and latched operands cleared. Reset asserted mid-operation aborts it on the same edge.
- States: IDLE, RUN, FINISH.
- IDLE, Start=1, Flush=0:
  - Op 100/101: Hi<=A (mthi) or Lo<=A (mtlo) on that edge; Done=1 next cycle; Busy stays 0; state stays IDLE.
  - Op 000-011: latch operands and op; go to RUN, Busy=1.
  - For signed ops (000, 010, 011), latch |A| and |B| and record neg = A[W-1]^B[W-1].
  - Reserved Op: ignored, no Done.
- RUN: each edge adds the partial product of the next STEP multiplier bits into a 2*WIDTH-bit product; counter 0..N-1; after N edges go to FINISH.
- FINISH, one edge:
  - P = neg ? -prod : prod.
  - mult/multu: {Hi,Lo}<=P.
  - madd: {Hi,Lo}<={Hi,Lo}+P.
  - msub: {Hi,Lo}<={Hi,Lo}-P.
  - All arithmetic is modulo 2^(2*WIDTH).
  - Then Done=1, Busy=0, state=IDLE.
- Latency: Start accepted at edge 0; Done high in the cycle following edge N+1, i.e. 34 cycles for the defaults. Busy is high in exactly N+1 cycles.
- Start while Busy: ignored, no queuing. The pipeline must respect Stall and Busy.
- A Start accepted in the Done cycle (state is IDLE) is legal: back-to-back operation.
- Flush:
  - In RUN/FINISH: return to IDLE on that edge; Hi/Lo unchanged; no Done.
  - Flush with Start in IDLE: Flush wins; command dropped.
- Hi/Lo change only at FINISH, mthi/mtlo, or Reset; never visibly mid-operation.
- Done never asserts in two consecutive cycles from one command.

Optional Feature:
- MULT_EARLY_TERM_EN defined: in RUN, if the remaining unretired multiplier bits are all zero, go to FINISH on the next edge. Latency becomes between 2 and N+1 cycles, e.g. 2 cycles when B=0.
- Result values are identical to the non-early-termination build.
- Undefined: fixed latency N+1.

Test Plan:
- mult A=7, B=0xFFFFFFFD -> Busy for 33 cycles; Done at cycle 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- multu A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- madd after mthi 0, mtlo 0x10, A=3, B=4 -> Lo=0x1C, Hi=0. Then msub A=2, B=0x10 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFC.
- mthi A=0x1234 -> Done next cycle, Busy never high, Hi=0x1234. Immediately follow with mult 2*3 -> Lo=6, Hi=0.
- HiLoRead held during mult -> Stall=1 in all 33 Busy cycles, 0 in the Done cycle. Start pulses during Busy are ignored, and the result is unchanged.
- Flush at RUN cycle 10, and separately Reset at cycle 20 -> no Done. Hi/Lo keep prior values (Flush) or are 0 (Reset). A following mult 5*5 gives Lo=25.

Source files
------------

// File: rtl/hilo_mult_sequencer.sv
// ============================================================================
//  Module   : hilo_mult_sequencer
//  Purpose  : Multi-cycle HI/LO multiply/accumulate unit (mult, multu, madd,
//             msub, mthi, mtlo) built as an iterative shift-add engine that
//             retires STEP multiplier bits per cycle.
//  Options  : define MULT_EARLY_TERM_EN to finish as soon as the remaining
//             multiplier bits are all zero (results are unchanged).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1    // 1, 2 or 4; must divide WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSTEPS - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   mcand_q;   // multiplicand, shifted left as bits retire
  logic [WIDTH-1:0]     mplier_q;  // multiplier, shifted right as bits retire
  logic [2*WIDTH-1:0]   prod_q;    // unsigned magnitude product accumulator
  logic [CW-1:0]        cnt_q;
  logic                 neg_q;     // magnitude product must be negated
  logic [1:0]           op_q;      // low op bits select mult/multu/madd/msub

  logic                 is_signed;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   signed_prod;
  logic [2*WIDTH-1:0]   hilo_d;
  logic                 run_last;

  // Operand conditioning: signed ops multiply magnitudes and fix the sign later
  always_comb begin
    is_signed = (Op != OP_MULTU);
    a_mag     = (is_signed && A[WIDTH-1]) ? ('0 - A) : A;
    b_mag     = (is_signed && B[WIDTH-1]) ? ('0 - B) : B;
  end

  // Partial product of the next STEP multiplier bits, added into the product
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) begin
        pp = pp + (mcand_q << i);
      end
    end
    prod_d = prod_q + pp;
  end

  // Last RUN edge: fixed count, or earlier once no multiplier bits remain
`ifdef MULT_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_bits;
  always_comb begin
    rem_bits = mplier_q >> STEP;
    run_last = (cnt_q == CNT_LAST) || (rem_bits == '0);
  end
`else
  always_comb begin
    run_last = (cnt_q == CNT_LAST);
  end
`endif

  // New {HI,LO} value committed in FINISH, modulo 2^(2*WIDTH)
  always_comb begin
    signed_prod = neg_q ? ('0 - prod_q) : prod_q;
    case (op_q)
      OP_MADD[1:0]: hilo_d = {hi_q, lo_q} + signed_prod;
      OP_MSUB[1:0]: hilo_d = {hi_q, lo_q} - signed_prod;
      default:      hilo_d = signed_prod;
    endcase
  end

  // Sequencer: command acceptance, iterative multiply and HI/LO commit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start && !Flush) begin
            case (Op)
              OP_MTHI: begin
                hi_q   <= A;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= A;
                done_q <= 1'b1;
              end
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                mplier_q <= b_mag;
                prod_q   <= '0;
                cnt_q    <= '0;
                neg_q    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                op_q     <= Op[1:0];
                state_q  <= S_RUN;
              end
              default: ;  // reserved opcodes are dropped silently
            endcase
          end
        end
        S_RUN: begin
          if (Flush) begin
            state_q <= S_IDLE;
          end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << STEP;
            mplier_q <= mplier_q >> STEP;
            cnt_q    <= cnt_q + 1'b1;
            if (run_last) begin
              state_q <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          if (Flush) begin
            state_q <= S_IDLE;
          end else begin
            {hi_q, lo_q} <= hilo_d;
            done_q       <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign Done  = done_q;
  assign Busy  = (state_q != S_IDLE);
  assign Stall = Busy & HiLoRead;

endmodule

`default_nettype wire
